// File: rtl/median_stream_ctrl_pkg.sv
// Shared types and helpers for the median filter stream controller and its
// coordinate counter.
package median_pkg;

  // Input sequencing states.
  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    RESYNC   = 2'd2
  } ctrl_state_t;

  // Column counter width; never below one bit.
  function automatic int col_w(input int img_width);
    return (img_width > 1) ? $clog2(img_width) : 1;
  endfunction

  // Row counter width; never below one bit.
  function automatic int row_w(input int img_height);
    return (img_height > 1) ? $clog2(img_height) : 1;
  endfunction

  // Smallest row/col index at which a KxK window is fully populated.
  function automatic int win_thr(input int kernel_size);
    return kernel_size - 1;
  endfunction

endpackage

// File: rtl/median_stream_ctrl_if.sv
// AXI4-Stream pixel link into the median filter.
//
// Handshake: a beat is transferred on a rising clock edge where tvalid and
// tready are both high. The master holds tdata/tuser/tlast stable while
// tvalid is high and tready is low; tready may change in any cycle and does
// not depend on tvalid. tuser marks pixel (0,0), tlast marks end of line.
interface median_stream_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tuser;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tuser, output tlast,
                  input  tready);
  modport slave  (input  tdata, input  tvalid, input  tuser, input  tlast,
                  output tready);
endinterface

// File: rtl/median_stream_ctrl_xy_counter.sv
// Raster-order column/row counter with wrap, synchronous clear and
// last-column / last-pixel flags. The counter holds the position of the
// next pixel; clear and increment together leave it at (1,0), i.e. the
// pixel just consumed was (0,0).
module median_xy_counter
  import median_pkg::*;
#(
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 1024,
  localparam int COL_W     = col_w(IMG_WIDTH),
  localparam int ROW_W     = row_w(IMG_HEIGHT)
) (
  input  logic             i_clk,
  input  logic             i_aresetn,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic             o_last_col,
  output logic             o_last_pix
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0] col_q, col_d, col_base;
  logic [ROW_W-1:0] row_q, row_d, row_base;

  // Next position: optional clear to origin, then optional raster advance.
  always_comb begin
    col_base = i_clr ? '0 : col_q;
    row_base = i_clr ? '0 : row_q;
    col_d    = col_base;
    row_d    = row_base;
    if (i_inc) begin
      if (col_base == COL_MAX) begin
        col_d = '0;
        row_d = (row_base == ROW_MAX) ? '0 : row_base + 1'b1;
      end else begin
        col_d = col_base + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign o_col      = col_q;
  assign o_row      = row_q;
  assign o_last_col = (col_q == COL_MAX);
  assign o_last_pix = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/median_stream_ctrl.sv
// Input-side sequencing controller for the 5x5 median filter: owns the
// stream ready, tracks frame position, checks tuser/tlast geometry,
// resynchronises on malformed frames and flags full-window pixels.
module median_stream_ctrl
  import median_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_WIDTH   = 1280,
  parameter int IMG_HEIGHT  = 1024,
  parameter int KERNEL_SIZE = 5,
  localparam int COL_W      = col_w(IMG_WIDTH),
  localparam int ROW_W      = row_w(IMG_HEIGHT)
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic                  i_enable,
  input  logic                  i_stall,
  median_stream_ctrl_if.slave   s_axis,
  output logic [DATA_WIDTH-1:0] o_pix_data,
  output logic                  o_pix_valid,
  output logic                  o_pix_sof,
  output logic                  o_window_valid,
  output logic [COL_W-1:0]      o_col,
  output logic [ROW_W-1:0]      o_row,
  output logic                  o_frame_done,
  output logic [15:0]           o_frame_cnt,
  output logic                  o_err_sof,
  output logic                  o_err_eol,
  output ctrl_state_t           o_dbg_state
);

  localparam int WIN_THR = win_thr(KERNEL_SIZE);

  ctrl_state_t      state_q, state_d;
  logic             rdy_q;
  logic             beat;
  logic             fwd, sof_d, win_d, done_d, err_sof_d, err_eol_d;
  logic             cnt_clr, cnt_inc;
  logic [COL_W-1:0] cnt_col, pix_col;
  logic [ROW_W-1:0] cnt_row, pix_row;
  logic             cnt_last_col, cnt_last_pix;

  logic [DATA_WIDTH-1:0] pix_data_q;
  logic                  pix_valid_q, pix_sof_q, window_valid_q;
  logic [COL_W-1:0]      col_q;
  logic [ROW_W-1:0]      row_q;
  logic                  frame_done_q, err_sof_q, err_eol_q;
  logic [15:0]           frame_cnt_q;

  assign s_axis.tready = rdy_q & ~i_stall;
  assign beat          = s_axis.tvalid & s_axis.tready;

  median_xy_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_xy (
    .i_clk      (i_clk),
    .i_aresetn  (i_aresetn),
    .i_clr      (cnt_clr),
    .i_inc      (cnt_inc),
    .o_col      (cnt_col),
    .o_row      (cnt_row),
    .o_last_col (cnt_last_col),
    .o_last_pix (cnt_last_pix)
  );

  // Ready comes up on the first clock after reset release.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) rdy_q <= 1'b0;
    else            rdy_q <= 1'b1;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) state_q <= WAIT_SOF;
    else            state_q <= state_d;
  end

  // Next state and per-beat decisions; tuser outranks every tlast check.
  always_comb begin
    state_d   = state_q;
    fwd       = 1'b0;
    sof_d     = 1'b0;
    done_d    = 1'b0;
    err_sof_d = 1'b0;
    err_eol_d = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    if (beat) begin
      unique case (state_q)
        WAIT_SOF, RESYNC: begin
          if (s_axis.tuser && i_enable) begin
            fwd     = 1'b1;
            sof_d   = 1'b1;
            cnt_clr = 1'b1;
            cnt_inc = 1'b1;
            state_d = ACTIVE;
          end
        end
        ACTIVE: begin
          if (s_axis.tuser) begin
            err_sof_d = 1'b1;
            if (i_enable) begin
              fwd     = 1'b1;
              sof_d   = 1'b1;
              cnt_clr = 1'b1;
              cnt_inc = 1'b1;
            end else begin
              state_d = WAIT_SOF;
            end
          end else if (s_axis.tlast && !cnt_last_col) begin
            err_eol_d = 1'b1;
            state_d   = RESYNC;
          end else begin
            fwd       = 1'b1;
            cnt_inc   = 1'b1;
            err_eol_d = cnt_last_col & ~s_axis.tlast;
            if (cnt_last_pix) begin
              done_d  = 1'b1;
              state_d = WAIT_SOF;
            end
          end
        end
        default: state_d = WAIT_SOF;
      endcase
    end
  end

  // Coordinates of the pixel being forwarded: a start-of-frame beat is (0,0).
  always_comb begin
    pix_col = sof_d ? '0 : cnt_col;
    pix_row = sof_d ? '0 : cnt_row;
    win_d   = fwd && (pix_row >= ROW_W'(WIN_THR)) && (pix_col >= COL_W'(WIN_THR));
  end

  // Registered outputs; strobes and error pulses last one cycle, pixel data
  // and coordinates hold the last forwarded values.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      pix_data_q     <= '0;
      pix_valid_q    <= 1'b0;
      pix_sof_q      <= 1'b0;
      window_valid_q <= 1'b0;
      col_q          <= '0;
      row_q          <= '0;
      frame_done_q   <= 1'b0;
      frame_cnt_q    <= '0;
      err_sof_q      <= 1'b0;
      err_eol_q      <= 1'b0;
    end else begin
      pix_valid_q    <= fwd;
      pix_sof_q      <= sof_d;
      window_valid_q <= win_d;
      frame_done_q   <= done_d;
      err_sof_q      <= err_sof_d;
      err_eol_q      <= err_eol_d;
      if (fwd) begin
        pix_data_q <= s_axis.tdata;
        col_q      <= pix_col;
        row_q      <= pix_row;
      end
      if (done_d) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign o_pix_data     = pix_data_q;
  assign o_pix_valid    = pix_valid_q;
  assign o_pix_sof      = pix_sof_q;
  assign o_window_valid = window_valid_q;
  assign o_col          = col_q;
  assign o_row          = row_q;
  assign o_frame_done   = frame_done_q;
  assign o_frame_cnt    = frame_cnt_q;
  assign o_err_sof      = err_sof_q;
  assign o_err_eol      = err_eol_q;
  assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_median_stream_ctrl.sv
// Self-checking bench for median_stream_ctrl on an 8x6 image, 5x5 kernel.
module tb_median_stream_ctrl;
  import median_pkg::*;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int K  = 5;
  localparam int CW = 3;
  localparam int RW = 3;
  localparam int VW = 6 + DW + CW + RW + 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic stall = 1'b0;
  always #5 clk = ~clk;

  median_stream_ctrl_if #(.DATA_WIDTH(DW)) axis ();

  logic [DW-1:0] o_pix_data;
  logic          o_pix_valid, o_pix_sof, o_window_valid;
  logic [CW-1:0] o_col;
  logic [RW-1:0] o_row;
  logic          o_frame_done, o_err_sof, o_err_eol;
  logic [15:0]   o_frame_cnt;
  ctrl_state_t   o_dbg_state;

  median_stream_ctrl #(
    .DATA_WIDTH (DW), .IMG_WIDTH (W), .IMG_HEIGHT (H), .KERNEL_SIZE (K)
  ) dut (
    .i_clk          (clk),
    .i_aresetn      (rst_n),
    .i_enable       (enable),
    .i_stall        (stall),
    .s_axis         (axis.slave),
    .o_pix_data     (o_pix_data),
    .o_pix_valid    (o_pix_valid),
    .o_pix_sof      (o_pix_sof),
    .o_window_valid (o_window_valid),
    .o_col          (o_col),
    .o_row          (o_row),
    .o_frame_done   (o_frame_done),
    .o_frame_cnt    (o_frame_cnt),
    .o_err_sof      (o_err_sof),
    .o_err_eol      (o_err_eol),
    .o_dbg_state    (o_dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [VW-1:0] exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string scen = "init";
  int    cnt_pix, cnt_win, cnt_done, cnt_esof, cnt_eeol;
  int    stall_at = -1;

  int            m_state;   // 0 wait-sof, 1 active, 2 resync
  int            m_col, m_row;
  logic [15:0]   m_frames;
  logic          m_rdy;
  logic [DW-1:0] m_odata;
  logic [CW-1:0] m_ocol;
  logic [RW-1:0] m_orow;

  function automatic logic [VW-1:0] dut_vec();
    return {o_pix_valid, o_pix_sof, o_window_valid, o_frame_done, o_err_sof,
            o_err_eol, o_pix_data, o_col, o_row, o_frame_cnt};
  endfunction

  task automatic model_reset();
    m_state = 0; m_col = 0; m_row = 0; m_frames = '0; m_rdy = 1'b0;
    m_odata = '0; m_ocol = '0; m_orow = '0;
    exp_q.delete();
  endtask

  // ---------------- driver: one clock cycle, entered at negedge ----------------
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic u,
                       input logic l, input logic s);
    logic exp_rdy, beat;
    logic e_valid, e_sof, e_win, e_done, e_esof, e_eeol;
    logic [VW-1:0] got, exp;
    axis.tvalid = v; axis.tdata = d; axis.tuser = u; axis.tlast = l; stall = s;
    #1;
    exp_rdy = m_rdy & ~s;
    n_checks++;
    if (axis.tready !== exp_rdy) begin
      n_errors++;
      $display("FAIL %s tready: got %b want %b", scen, axis.tready, exp_rdy);
    end
    beat = v & exp_rdy;
    {e_valid, e_sof, e_win, e_done, e_esof, e_eeol} = '0;
    if (beat) begin
      if (m_state != 1 || u) begin
        if (m_state == 1) e_esof = 1'b1;
        if (u && enable) begin
          e_valid = 1'b1; e_sof = 1'b1;
          m_odata = d; m_ocol = '0; m_orow = '0;
          m_col = 1; m_row = 0; m_state = 1;
        end else if (u) begin
          m_state = 0;
        end
      end else if (l && m_col != W - 1) begin
        e_eeol = 1'b1; m_state = 2;
      end else begin
        e_eeol  = (m_col == W - 1) && !l;
        e_valid = 1'b1;
        e_win   = (m_row >= K - 1) && (m_col >= K - 1);
        m_odata = d; m_ocol = CW'(m_col); m_orow = RW'(m_row);
        if (m_col == W - 1 && m_row == H - 1) begin
          e_done = 1'b1; m_frames = m_frames + 16'd1; m_state = 0;
        end
        if (m_col == W - 1) begin
          m_col = 0;
          m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end else begin
          m_col = m_col + 1;
        end
      end
    end
    exp_q.push_back({e_valid, e_sof, e_win, e_done, e_esof, e_eeol,
                     m_odata, m_ocol, m_orow, m_frames});
    @(posedge clk);
    m_rdy = 1'b1;
    @(negedge clk);
    got = dut_vec();
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s outputs: got %h want <empty queue>", scen, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_errors++;
        $display("FAIL %s outputs {v,sof,win,done,esof,eeol,data,col,row,fcnt}: got %h want %h",
                 scen, got, exp);
      end
    end
    if (o_pix_valid)    cnt_pix++;
    if (o_window_valid) cnt_win++;
    if (o_frame_done)   cnt_done++;
    if (o_err_sof)      cnt_esof++;
    if (o_err_eol)      cnt_eeol++;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Raster beats [from,to); tuser at sof_at, tlast at line end and at eol_at.
  task automatic send_beats(input int from, input int to, input int sof_at, input int eol_at);
    for (int k = from; k < to; k++) begin
      logic [DW-1:0] d;
      logic u, l;
      d = DW'($urandom_range(0, 255));
      u = (k == sof_at);
      l = ((k % W) == W - 1) || (k == eol_at);
      if (k == stall_at) repeat (4) drive(1'b1, d, u, l, 1'b1);
      drive(1'b1, d, u, l, 1'b0);
    end
  endtask

  task automatic clear_counts();
    cnt_pix = 0; cnt_win = 0; cnt_done = 0; cnt_esof = 0; cnt_eeol = 0;
  endtask

  task automatic check_int(input string what, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s %s: got %0d want %0d", scen, what, got, want);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    axis.tvalid = 1'b0; axis.tuser = 1'b0; axis.tlast = 1'b0; axis.tdata = '0;
    stall = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== '0 || axis.tready !== 1'b0) begin
      n_errors++;
      $display("FAIL %s reset outputs: got %h/%b want 0/0", scen, dut_vec(), axis.tready);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (o_dbg_state !== WAIT_SOF || o_frame_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL %s reset state: got %0d/%0d want 0/0", scen, o_dbg_state, o_frame_cnt);
    end
    rst_n = 1'b1;
    idle();   // ready still low this cycle, high after it
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    scen = "reset";
    do_reset();
    idle();
  endtask

  task automatic test_clean_frame();
    scen = "clean_frame"; clear_counts();
    send_beats(0, 48, 0, -1);
    idle();
    check_int("pix_count", cnt_pix, 48);
    check_int("win_count", cnt_win, 8);
    check_int("done_count", cnt_done, 1);
    check_int("frame_cnt", int'(o_frame_cnt), 1);
    check_int("err_count", cnt_esof + cnt_eeol, 0);
  endtask

  task automatic test_junk_before_sof();
    scen = "junk_sof"; clear_counts();
    send_beats(40, 43, -1, -1);
    check_int("junk_pix", cnt_pix, 0);
    send_beats(0, 48, 0, -1);
    check_int("pix_count", cnt_pix, 48);
  endtask

  task automatic test_mid_sof();
    scen = "mid_sof"; clear_counts();
    send_beats(0, 19, 0, -1);
    send_beats(0, 48, 0, -1);
    check_int("err_sof_count", cnt_esof, 1);
    check_int("done_count", cnt_done, 1);
    check_int("pix_count", cnt_pix, 19 + 48);
  endtask

  task automatic test_eol_err();
    scen = "eol_err"; clear_counts();
    send_beats(0, 14, 0, 13);
    send_beats(14, 22, -1, -1);
    check_int("err_eol_count", cnt_eeol, 1);
    check_int("pix_count", cnt_pix, 13);
    check_int("dbg_state", int'(o_dbg_state), int'(RESYNC));
    send_beats(0, 48, 0, -1);
    check_int("done_count", cnt_done, 1);
  endtask

  task automatic test_stall();
    scen = "stall"; clear_counts();
    stall_at = 11;
    send_beats(0, 48, 0, -1);
    stall_at = -1;
    check_int("pix_count", cnt_pix, 48);
    check_int("done_count", cnt_done, 1);
  endtask

  task automatic test_enable_off();
    scen = "enable_off"; clear_counts();
    enable = 1'b0;
    send_beats(0, 10, 0, -1);
    check_int("pix_count", cnt_pix, 0);
    send_beats(0, 5, 0, -1);
    enable = 1'b1;
    send_beats(0, 48, 0, -1);
    check_int("pix_count_after", cnt_pix, 48);
  endtask

  task automatic test_back_to_back();
    scen = "back_to_back"; clear_counts();
    send_beats(0, 48, 0, -1);
    send_beats(0, 20, 0, -1);
    idle(); idle();
    send_beats(20, 48, 0, -1);
    check_int("done_count", cnt_done, 2);
    check_int("err_count", cnt_esof + cnt_eeol, 0);
  endtask

  task automatic test_reset_mid();
    scen = "reset_mid"; clear_counts();
    send_beats(0, 29, 0, -1);
    do_reset();
    check_int("frame_cnt", int'(o_frame_cnt), 0);
    clear_counts();
    send_beats(29, 48, -1, -1);
    check_int("dropped_pix", cnt_pix, 0);
    send_beats(0, 48, 0, -1);
    check_int("done_count", cnt_done, 1);
    check_int("frame_cnt_after", int'(o_frame_cnt), 1);
  endtask

  initial begin
    axis.tvalid = 1'b0; axis.tuser = 1'b0; axis.tlast = 1'b0; axis.tdata = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_clean_frame();
    test_junk_before_sof();
    test_mid_sof();
    test_eol_err();
    test_stall();
    test_enable_off();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
